counter_watch: RTL



---
 rtl/counter_watch_pkg.sv | 16 +
 rtl/counter_watch_if.sv | 23 ++
 rtl/counter_watch_fifo.sv | 46 ++++
 rtl/counter_watch.sv | 119 +++++++++++
 4 files changed

// File: rtl/counter_watch_pkg.sv
// rtl/counter_watch_pkg.sv - shared event codes and widths for counter_watch
package counter_watch_pkg;

    localparam logic [1:0] EVT_NONE  = 2'b00;
    localparam logic [1:0] EVT_WRAP  = 2'b01;
    localparam logic [1:0] EVT_MATCH = 2'b10;
    localparam logic [1:0] EVT_STALL = 2'b11;

    localparam int DropWidth = 8;

    // A queued record is {event code, timestamp}
    function automatic int rec_width(input int ts_width);
        return 2 + ts_width;
    endfunction

endpackage

// File: rtl/counter_watch_if.sv
// rtl/counter_watch_if.sv - event record stream between counter_watch and its consumer
interface counter_watch_if #(
    parameter int TsWidth = 16
);
    logic               evt_valid;
    logic               evt_ready;
    logic [1:0]         evt_type;
    logic [TsWidth-1:0] evt_time;

    modport master (
        output evt_valid,
        output evt_type,
        output evt_time,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_type,
        input  evt_time,
        output evt_ready
    );
endinterface

// File: rtl/counter_watch_fifo.sv
// rtl/counter_watch_fifo.sv - show-ahead synchronous FIFO, async active-low reset
module counter_watch_fifo #(
    parameter int Width = 18,
    parameter int Depth = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [Width-1:0] i_wdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [Width-1:0] o_rdata
);
    localparam int AW = $clog2(Depth);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [Width-1:0] r_mem [Depth];

    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // When full, the write slot is the head being popped this edge, so the push is safe
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/counter_watch.sv
// rtl/counter_watch.sv - watches a counter value for wrap, match and stall events
// and queues timestamped records for a downstream consumer.
module counter_watch
    import counter_watch_pkg::*;
#(
    parameter int Size       = 5,
    parameter int Depth      = 4,
    parameter int TsWidth    = 16,
    parameter int StallLimit = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [Size-1:0]      count,
    input  logic [Size-1:0]      match_value,
    input  logic                 match_en,
    input  logic                 clear_overflow,
    counter_watch_if.master      evt,
    output logic                 overflow,
    output logic [DropWidth-1:0] drop_count
);
    localparam int RecW = rec_width(TsWidth);
    localparam int RepW = $clog2(StallLimit + 1);
    localparam logic [Size-1:0] MaxCount = '1;

    logic [TsWidth-1:0]   r_ts;
    logic [Size-1:0]      r_prev;
    logic                 r_have_prev;
    logic [RepW-1:0]      r_rep;
    logic                 r_armed;
    logic                 r_overflow;
    logic [DropWidth-1:0] r_drop_count;

    logic                 w_same;
    logic                 w_changed;
    logic                 w_wrap;
    logic                 w_match;
    logic                 w_stall;
    logic                 w_push;
    logic [1:0]           w_type;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic [RecW-1:0]      w_rdata;
    logic [1:0]           w_drops;
    logic [DropWidth-1:0] w_drop_base;
    logic [DropWidth:0]   w_drop_sum;
    logic [DropWidth-1:0] w_drop_next;

    // Nothing is detected until a previous sample exists
    assign w_same    = r_have_prev && (count == r_prev);
    assign w_changed = r_have_prev && (count != r_prev);
    assign w_wrap    = r_have_prev && (r_prev == MaxCount) && (count == '0);
    assign w_match   = w_changed && match_en && (count == match_value);
    assign w_stall   = w_same && r_armed && (r_rep == RepW'(StallLimit - 1));
    assign w_push    = w_wrap || w_match || w_stall;
    assign w_pop     = !w_empty && evt.evt_ready;

    always_comb begin
        w_type = EVT_NONE;
        if (w_wrap)       w_type = EVT_WRAP;
        else if (w_match) w_type = EVT_MATCH;
        else if (w_stall) w_type = EVT_STALL;
    end

    // A match coinciding with a wrap is discarded and counted as a drop
    always_comb begin
        w_drops     = {1'b0, w_wrap && w_match} + {1'b0, w_push && w_full && !w_pop};
        w_drop_base = clear_overflow ? '0 : r_drop_count;
        w_drop_sum  = {1'b0, w_drop_base} + {(DropWidth - 1)'(0), w_drops};
        w_drop_next = w_drop_sum[DropWidth] ? '1 : w_drop_sum[DropWidth-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ts         <= '0;
            r_prev       <= '0;
            r_have_prev  <= 1'b0;
            r_rep        <= '0;
            r_armed      <= 1'b1;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_ts        <= r_ts + TsWidth'(1);
            r_prev      <= count;
            r_have_prev <= 1'b1;
            if (w_same) begin
                if (r_rep != RepW'(StallLimit)) r_rep <= r_rep + RepW'(1);
            end else begin
                r_rep <= '0;
            end
            if (w_stall)        r_armed <= 1'b0;
            else if (w_changed) r_armed <= 1'b1;
            if (w_drops != 2'd0)     r_overflow <= 1'b1;
            else if (clear_overflow) r_overflow <= 1'b0;
            r_drop_count <= w_drop_next;
        end
    end

    counter_watch_fifo #(
        .Width (RecW),
        .Depth (Depth)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({w_type, r_ts}),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_rdata (w_rdata)
    );

    assign evt.evt_valid = !w_empty;
    assign evt.evt_type  = w_rdata[TsWidth +: 2];
    assign evt.evt_time  = w_rdata[TsWidth-1:0];
    assign overflow      = r_overflow;
    assign drop_count    = r_drop_count;

endmodule
